mul_feeder: RTL and testbench

Upstream operand sequencer for the 8x8 shift-add multiplier. Accepts operand pairs over a valid/ready interface and buffers them in a small FIFO. Issues each pair to the multiplier with a one-cycle start pulse, tracks the multiplier's ack handshake, and presents each 16-bit product on a registered valid/ready output in arrival order.

---
 rtl/mul_feeder.sv | 116 +++++++++++
 tb/tb_mul_feeder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_feeder.sv
// mul_feeder: operand FIFO and one-at-a-time sequencer for the 8x8 shift-add multiplier.
// Build option MUL_FEEDER_ZERO_BYPASS_EN: pairs with a zero operand skip the multiplier.
module mul_feeder #(
  parameter int DEPTH = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic        mul_start,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic        mul_ack,
  input  logic [15:0] mul_r,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_r,
  output logic        busy
);
  localparam int DATA_W = 8;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI, OUT} state_t;

  state_t state, state_nxt;

  logic [2*DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count;
  logic                push, pop, bypass;
  logic [DATA_W-1:0]   pop_a, pop_b;

  assign in_ready       = (count != FULL);
  assign push           = in_valid && in_ready;
  assign pop            = (state == IDLE) && (count != '0);
  assign {pop_a, pop_b} = mem[rd_ptr];
  assign busy           = (state != IDLE) || (count != '0);

`ifdef MUL_FEEDER_ZERO_BYPASS_EN
  assign bypass = (pop_a == '0) || (pop_b == '0);
`else
  assign bypass = 1'b0;
`endif

  // Operand FIFO: storage is data, only pointers and count are reset.
  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= {in_a, in_b};
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sequencer state register and next-state logic.
  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pop) state_nxt = bypass ? OUT : ISSUE;
      ISSUE:   state_nxt = WAIT_LO;
      // Ack may still be high from the previous product; wait for it to drop first.
      WAIT_LO: if (!mul_ack) state_nxt = WAIT_HI;
      WAIT_HI: if (mul_ack) state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered multiplier drive and product output.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      out_valid <= 1'b0;
      out_r     <= '0;
    end else begin
      mul_start <= 1'b0;
      if (pop && !bypass) begin
        mul_start <= 1'b1;
        mul_a     <= pop_a;
        mul_b     <= pop_b;
      end
      if (pop && bypass) begin
        out_r     <= '0;
        out_valid <= 1'b1;
      end
      if ((state == WAIT_HI) && mul_ack) begin
        out_r     <= mul_r;
        out_valid <= 1'b1;
      end
      if ((state == OUT) && out_ready) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mul_feeder.sv
// Directed bench for mul_feeder, with a behavioural shift-add multiplier that takes
// bitlen(B) cycles and holds ack high until its next start.
module tb_mul_feeder;
  localparam int DEPTH = 4;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_a = '0, in_b = '0;
  logic        out_ready = 1'b1;
  logic        in_ready, mul_start, out_valid, busy;
  logic [7:0]  mul_a, mul_b;
  logic [15:0] out_r;
  logic        mul_ack = 1'b0;
  logic [15:0] mul_r = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mul_feeder #(.DEPTH(DEPTH)) dut (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_ack(mul_ack), .mul_r(mul_r), .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .busy(busy)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Multiplier model (no reset, like the real block).
  logic        m_run = 1'b0;
  int          m_cnt = 0;
  logic [15:0] m_prod = '0;

  function automatic int bitlen(input logic [7:0] v);
    int n = 0;
    for (int i = 0; i < 8; i++) if (v[i]) n = i + 1;
    return n;
  endfunction

  always @(posedge Clk) begin
    if (mul_start === 1'b1) begin
      m_run   <= 1'b1;
      mul_ack <= 1'b0;
      m_cnt   <= bitlen(mul_b);
      m_prod  <= 16'(mul_a) * 16'(mul_b);
    end else if (m_run) begin
      if (m_cnt == 0) begin
        mul_ack <= 1'b1;
        mul_r   <= m_prod;
        m_run   <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // Start-pulse observer: counts starts, over-wide pulses and starts too soon after an ack.
  logic ack_q = 1'b0, start_q = 1'b0;
  int   ack_rise = -100, gap_viol = 0, wide = 0, starts = 0;

  always @(negedge Clk) begin
    ack_q   <= mul_ack;
    start_q <= (mul_start === 1'b1);
    if (mul_ack && !ack_q) ack_rise <= cyc;
    if ((mul_start === 1'b1) && !start_q) begin
      starts <= starts + 1;
      if (cyc - ack_rise < 3) gap_viol <= gap_viol + 1;
    end
    if ((mul_start === 1'b1) && start_q) wide <= wide + 1;
  end

  task automatic push(input logic [7:0] a, input logic [7:0] b, output int t);
    in_valid = 1'b1; in_a = a; in_b = b;
    for (int i = 0; i < 200 && in_ready !== 1'b1; i++) @(negedge Clk);
    if (in_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL push_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge Clk);
    @(negedge Clk);
    t = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int c, output logic [15:0] r, output bit to);
    to = 1'b1; c = 0; r = 'x;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (out_valid === 1'b1) begin
        c = cyc; r = out_r; to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    Rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (12) @(negedge Clk);
    checks++;
    if ({in_ready, mul_start, mul_a, mul_b, out_valid, out_r, busy} !== {1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 16'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: got rdy=%b st=%b a=%0d b=%0d ov=%b r=%0d busy=%b required 1 0 0 0 0 0 0",
               in_ready, mul_start, mul_a, mul_b, out_valid, out_r, busy);
    end
    Rst = 1'b0;
    @(negedge Clk);
    checks++;
    if ({in_ready, mul_start, out_valid, busy} !== 4'b1000) begin
      errors++;
      $display("FAIL idle_after_reset: got rdy/st/ov/busy=%b required 1000", {in_ready, mul_start, out_valid, busy});
    end
  endtask

  task automatic test_single;
    int t, c; logic [15:0] r; bit to;
    push(8'd5, 8'd7, t);
    @(negedge Clk);
    checks++; if (mul_start !== 1'b1) begin errors++; $display("FAIL start_t1: got %b required 1", mul_start); end
    checks++; if ({mul_a, mul_b} !== {8'd5, 8'd7}) begin errors++; $display("FAIL operands: got %0d,%0d required 5,7", mul_a, mul_b); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_single: got %b required 1", busy); end
    @(negedge Clk);
    checks++; if (mul_start !== 1'b0) begin errors++; $display("FAIL start_t2: got %b required 0", mul_start); end
    wait_out(c, r, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL single_timeout: no out_valid within bound"); end
    checks++; if (c - t !== 7) begin errors++; $display("FAIL single_latency: got %0d required 7", c - t); end
    checks++; if (r !== 16'd35) begin errors++; $display("FAIL single_product: got %0d required 35", r); end
    @(negedge Clk);
    checks++;
    if ({out_valid, busy, mul_a} !== {1'b0, 1'b0, 8'd5}) begin
      errors++;
      $display("FAIL single_done: got ov=%b busy=%b a=%0d required 0 0 5", out_valid, busy, mul_a);
    end
  endtask

  task automatic test_back_to_back;
    int t0, t1, t2, c; logic [15:0] r; bit to;
    int v0, w0;
    int exp_c [3];
    logic [15:0] exp_r [3];
`ifdef MUL_FEEDER_ZERO_BYPASS_EN
    exp_c = '{12, 14, 20};
`else
    exp_c = '{12, 21, 27};
`endif
    exp_r = '{16'd65025, 16'd0, 16'd3};
    v0 = gap_viol; w0 = wide;
    out_ready = 1'b1;
    push(8'd255, 8'd255, t0);
    push(8'd0, 8'd9, t1);
    push(8'd3, 8'd1, t2);
    checks++; if (t1 - t0 !== 1 || t2 - t0 !== 2) begin errors++; $display("FAIL b2b_push_spacing: got %0d,%0d required 1,2", t1 - t0, t2 - t0); end
    for (int k = 0; k < 3; k++) begin
      wait_out(c, r, to);
      checks++;
      if (to !== 1'b0 || r !== exp_r[k] || c - t0 !== exp_c[k]) begin
        errors++;
        $display("FAIL b2b_out%0d: got r=%0d at t+%0d (timeout=%b) required r=%0d at t+%0d", k, r, c - t0, to, exp_r[k], exp_c[k]);
      end
    end
    repeat (2) @(negedge Clk);
    checks++; if (gap_viol !== v0) begin errors++; $display("FAIL start_gap: got %0d early starts required %0d", gap_viol, v0); end
    checks++; if (wide !== w0) begin errors++; $display("FAIL start_width: got %0d wide cycles required %0d", wide, w0); end
  endtask

  task automatic test_stall;
    logic [7:0]  a [6];
    logic [7:0]  b [6];
    logic [15:0] exp_r [6];
    int acc; bit was; int c; logic [15:0] r; bit to;
    a = '{8'd1, 8'd3, 8'd10, 8'd255, 8'd17, 8'd200};
    b = '{8'd2, 8'd4, 8'd20, 8'd1, 8'd17, 8'd100};
    exp_r = '{16'd2, 16'd12, 16'd200, 16'd255, 16'd289, 16'd20000};
    acc = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_a = a[acc]; in_b = b[acc];
      was = in_ready;
      @(negedge Clk);
      if (was) acc++;
      if (acc > 5) break;
    end
    checks++; if (acc !== DEPTH + 1) begin errors++; $display("FAIL stall_accepted: got %0d required %0d", acc, DEPTH + 1); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_full: in_ready got %b required 0", in_ready); end
    checks++; if ({out_valid, out_r} !== {1'b1, 16'd2}) begin errors++; $display("FAIL stall_first: got ov=%b r=%0d required 1 2", out_valid, out_r); end
    repeat (3) @(negedge Clk);
    checks++; if ({out_valid, out_r} !== {1'b1, 16'd2}) begin errors++; $display("FAIL stall_hold: got ov=%b r=%0d required 1 2", out_valid, out_r); end
    out_ready = 1'b1;
    @(negedge Clk);
    checks++; if ({out_valid, in_ready} !== 2'b00) begin errors++; $display("FAIL pop_cycle_ready: got ov=%b rdy=%b required 0 0", out_valid, in_ready); end
    @(negedge Clk);
    checks++;
    if ({in_ready, mul_start, mul_a, mul_b} !== {1'b1, 1'b1, 8'd3, 8'd4}) begin
      errors++;
      $display("FAIL after_pop: got rdy=%b st=%b a=%0d b=%0d required 1 1 3 4", in_ready, mul_start, mul_a, mul_b);
    end
    @(negedge Clk);
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL refilled: in_ready got %b required 0", in_ready); end
    for (int k = 1; k < 6; k++) begin
      wait_out(c, r, to);
      checks++;
      if (to !== 1'b0 || r !== exp_r[k]) begin
        errors++;
        $display("FAIL stall_out%0d: got r=%0d (timeout=%b) required %0d", k, r, to, exp_r[k]);
      end
    end
    repeat (2) @(negedge Clk);
    checks++; if ({busy, in_ready} !== 2'b01) begin errors++; $display("FAIL stall_drained: got busy=%b rdy=%b required 0 1", busy, in_ready); end
  endtask

  task automatic test_reset_mid_op;
    int t, t2, c, seen; logic [15:0] r; bit to;
    push(8'd9, 8'd255, t);
    push(8'd7, 8'd7, t2);
    repeat (3) @(negedge Clk);
    Rst = 1'b1;
    repeat (10) @(negedge Clk);
    checks++;
    if ({in_ready, mul_start, mul_a, mul_b, out_valid, out_r, busy} !== {1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 16'd0, 1'b0}) begin
      errors++;
      $display("FAIL midop_reset_values: got rdy=%b st=%b a=%0d b=%0d ov=%b r=%0d busy=%b required 1 0 0 0 0 0 0",
               in_ready, mul_start, mul_a, mul_b, out_valid, out_r, busy);
    end
    Rst = 1'b0;
    @(negedge Clk);
    checks++; if ({busy, out_valid, mul_start} !== 3'b000) begin errors++; $display("FAIL midop_flushed: got busy/ov/st=%b required 000", {busy, out_valid, mul_start}); end
    push(8'd2, 8'd3, t);
    wait_out(c, r, to);
    checks++;
    if (to !== 1'b0 || r !== 16'd6 || c - t !== 6) begin
      errors++;
      $display("FAIL midop_next: got r=%0d at t+%0d (timeout=%b) required 6 at t+6", r, c - t, to);
    end
    seen = 0;
    repeat (30) begin
      @(negedge Clk);
      if (out_valid === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midop_stale: got %0d extra product cycles required 0", seen); end
  endtask

  task automatic test_zero_operand;
    int t, c, s0; logic [15:0] r; bit to;
    s0 = starts;
    push(8'd0, 8'd200, t);
    wait_out(c, r, to);
    checks++; if (to !== 1'b0 || r !== 16'd0) begin errors++; $display("FAIL zero_product: got %0d (timeout=%b) required 0", r, to); end
    repeat (2) @(negedge Clk);
`ifdef MUL_FEEDER_ZERO_BYPASS_EN
    checks++; if (c - t !== 1) begin errors++; $display("FAIL zero_latency: got %0d required 1", c - t); end
    checks++; if (starts - s0 !== 0) begin errors++; $display("FAIL zero_starts: got %0d required 0", starts - s0); end
    checks++; if ({mul_a, mul_b} !== {8'd2, 8'd3}) begin errors++; $display("FAIL zero_operands: got %0d,%0d required 2,3", mul_a, mul_b); end
`else
    checks++; if (c - t !== 12) begin errors++; $display("FAIL zero_latency: got %0d required 12", c - t); end
    checks++; if (starts - s0 !== 1) begin errors++; $display("FAIL zero_starts: got %0d required 1", starts - s0); end
    checks++; if ({mul_a, mul_b} !== {8'd0, 8'd200}) begin errors++; $display("FAIL zero_operands: got %0d,%0d required 0,200", mul_a, mul_b); end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_mid_op();
    test_zero_operand();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
